// File: rtl/de270_cpu_ocimem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : de270_cpu_ocimem_pkg
//  Description : Shared constants and types for the OCI memory arbiter:
//                FSM state encoding, jdo field positions, RAM geometry and
//                the CPU starvation limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package de270_cpu_ocimem_pkg;

    // OCI RAM geometry
    localparam int unsigned RAM_DEPTH    = 256;
    localparam int unsigned RAM_WIDTH    = 32;
    localparam int unsigned RAM_AW       = 8;
    localparam int unsigned RAM_BE_W     = RAM_WIDTH / 8;

    // jdo field positions
    localparam int unsigned JDO_W        = 38;
    localparam int unsigned JDO_ADDR_MSB = 33;
    localparam int unsigned JDO_ADDR_LSB = 26;
    localparam int unsigned JDO_MODE_BIT = 35;
    localparam int unsigned JDO_DATA_MSB = 34;
    localparam int unsigned JDO_DATA_LSB = 3;

    // Consecutive JTAG grants tolerated while the CPU waits
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned STARVE_W     = 3;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_J_RD = 2'd1,
        ST_C_RD = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/de270_cpu_ocimem_jtag_req.sv
`default_nettype none
// ============================================================================
//  Module      : de270_cpu_ocimem_jtag_req
//  Description : Single-entry JTAG request latch. Decodes the three JTAG
//                pulses, queues at most one RAM access, and flags pulses
//                that arrive while the entry is still occupied.
//  Revision    : 1.0 - initial release
// ============================================================================
module de270_cpu_ocimem_jtag_req
    import de270_cpu_ocimem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic take_a,      // address/mode load pulse
    input  logic take_b,      // write data pulse
    input  logic take_no_a,   // read-next pulse
    input  logic jdo_mode,    // mode bit carried with take_a
    input  logic mode,        // currently latched mode (1 = write)
    input  logic inflight,    // a JTAG read is waiting for its data
    input  logic grant,       // pending entry is issued to the RAM this cycle
    input  logic complete,    // the JTAG operation finishes this cycle
    output logic pending,     // entry waiting for a grant
    output logic pend_we,     // pending entry is a write
    output logic load_a,      // accepted take_a: load address and mode
    output logic load_b,      // accepted take_b: load write data
    output logic accept,      // any accepted pulse
    output logic new_req,     // an access is queued this cycle
    output logic overflow     // pulse dropped because the entry is busy
);

    logic r_pending;
    logic r_pend_we;
    logic w_busy;
    logic w_free;
    logic w_valid;
    logic w_rd_next;
    logic w_queue_rd;

    // The entry stays occupied from acceptance until the access completes;
    // a pulse in the completion cycle itself is allowed in.
    assign w_busy     = r_pending | inflight;
    assign w_free     = ~w_busy | complete;
    assign w_valid    = take_a | take_b | (take_no_a & ~mode);

    // take_a has priority over take_b, which has priority over take_no_a
    assign load_a     = take_a & w_free;
    assign load_b     = ~take_a & take_b & w_free;
    assign w_rd_next  = ~take_a & ~take_b & take_no_a & ~mode & w_free;
    assign w_queue_rd = (load_a & ~jdo_mode) | w_rd_next;

    assign accept     = load_a | load_b | w_rd_next;
    assign new_req    = w_queue_rd | load_b;
    assign overflow   = w_valid & ~w_free;
    assign pending    = r_pending;
    assign pend_we    = r_pend_we;

    // Entry occupancy: a newly queued access replaces the one being granted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_pend_we <= 1'b0;
        end else if (new_req) begin
            r_pending <= 1'b1;
            r_pend_we <= load_b;
        end else if (grant) begin
            r_pending <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/de270_cpu_ocimem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : de270_cpu_ocimem_arbiter
//  Description : Shares the single-port 256x32 OCI RAM between the JTAG
//                debug path and the CPU slave. JTAG has priority, with a
//                starvation guard that hands the CPU a grant after a run of
//                JTAG grants while it waits.
//  Revision    : 1.0 - initial release
// ============================================================================
module de270_cpu_ocimem_arbiter
    import de270_cpu_ocimem_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [JDO_W-1:0]      jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    input  logic                  take_no_action_ocimem_a,
    output logic [RAM_WIDTH-1:0]  MonDReg,
    output logic                  monitor_ready,
    output logic                  monitor_error,
    input  logic [RAM_AW-1:0]     cpu_address,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [RAM_WIDTH-1:0]  cpu_writedata,
    input  logic [RAM_BE_W-1:0]   cpu_byteenable,
    output logic [RAM_WIDTH-1:0]  cpu_readdata,
    output logic                  cpu_waitrequest,
    output logic [RAM_AW-1:0]     ram_addr,
    output logic                  ram_we,
    output logic [RAM_BE_W-1:0]   ram_be,
    output logic [RAM_WIDTH-1:0]  ram_wdata,
    input  logic [RAM_WIDTH-1:0]  ram_rdata
);

    localparam logic [STARVE_W-1:0] C_STARVE_LIMIT = STARVE_W'(STARVE_LIMIT);

    state_t                  r_state;
    logic [RAM_AW-1:0]       r_mon_areg;
    logic [RAM_WIDTH-1:0]    r_mon_dreg;
    logic                    r_mode;
    logic                    r_ready;
    logic                    r_error;
    logic [STARVE_W-1:0]     r_starve;
    logic [RAM_WIDTH-1:0]    r_cpu_rdata;

    logic w_pending;
    logic w_pend_we;
    logic w_load_a;
    logic w_load_b;
    logic w_accept;
    logic w_new_req;
    logic w_overflow;
    logic w_idle;
    logic w_cpu_req;
    logic w_starved;
    logic w_cpu_grant;
    logic w_jtag_grant;
    logic w_jtag_done;
    logic w_in_jrd;
    logic w_in_crd;
    logic w_unused_jdo;

    assign w_unused_jdo = ^{jdo[JDO_W-1:JDO_MODE_BIT+1], jdo[JDO_DATA_LSB-1:0]};

    assign w_in_jrd  = (r_state == ST_J_RD);
    assign w_in_crd  = (r_state == ST_C_RD);
    assign w_idle    = (r_state == ST_IDLE) & ~reset;
    assign w_cpu_req = cpu_read | cpu_write;
    assign w_starved = (r_starve >= C_STARVE_LIMIT);

    // A JTAG pulse landing this cycle already counts as a competing request,
    // so the CPU stalls behind it unless it has been starved.
    assign w_cpu_grant  = w_idle & w_cpu_req & (~(w_pending | w_new_req) | w_starved);
    assign w_jtag_grant = w_idle & w_pending & ~w_cpu_grant;
    assign w_jtag_done  = (w_jtag_grant & w_pend_we) | w_in_jrd;

    de270_cpu_ocimem_jtag_req u_jtag_req (
        .clk       (clk),
        .reset     (reset),
        .take_a    (take_action_ocimem_a),
        .take_b    (take_action_ocimem_b),
        .take_no_a (take_no_action_ocimem_a),
        .jdo_mode  (jdo[JDO_MODE_BIT]),
        .mode      (r_mode),
        .inflight  (w_in_jrd),
        .grant     (w_jtag_grant),
        .complete  (w_jtag_done),
        .pending   (w_pending),
        .pend_we   (w_pend_we),
        .load_a    (w_load_a),
        .load_b    (w_load_b),
        .accept    (w_accept),
        .new_req   (w_new_req),
        .overflow  (w_overflow)
    );

    // Single RAM port: the granted requester drives address and write data
    always_comb begin
        ram_addr  = cpu_address;
        ram_be    = cpu_byteenable;
        ram_wdata = cpu_writedata;
        ram_we    = w_cpu_grant & cpu_write;
        if (w_jtag_grant) begin
            ram_addr  = r_mon_areg;
            ram_be    = {RAM_BE_W{1'b1}};
            ram_wdata = r_mon_dreg;
            ram_we    = w_pend_we;
        end
    end

    // CPU handshake: writes finish in their grant cycle, reads in C_RD
    always_comb begin
        cpu_waitrequest = w_cpu_req & ~((w_cpu_grant & cpu_write) | w_in_crd);
        cpu_readdata    = w_in_crd ? ram_rdata : r_cpu_rdata;
    end

    assign MonDReg       = r_mon_dreg;
    assign monitor_ready = r_ready;
    assign monitor_error = r_error;

    // Arbiter FSM: reads take a data-return cycle, writes never leave IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_jtag_grant && !w_pend_we) begin
                        r_state <= ST_J_RD;
                    end else if (w_cpu_grant && !cpu_write) begin
                        r_state <= ST_C_RD;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // JTAG address/mode register; a fresh address load beats the increment
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mon_areg <= '0;
            r_mode     <= 1'b0;
        end else if (w_load_a) begin
            r_mon_areg <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
            r_mode     <= jdo[JDO_MODE_BIT];
        end else if (w_jtag_done) begin
            r_mon_areg <= r_mon_areg + 8'd1;
        end
    end

    // JTAG data register; new write data beats a read capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mon_dreg <= '0;
        end else if (w_load_b) begin
            r_mon_dreg <= jdo[JDO_DATA_MSB:JDO_DATA_LSB];
        end else if (w_in_jrd) begin
            r_mon_dreg <= ram_rdata;
        end
    end

    // Ready/error status; a newly accepted pulse keeps ready low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b1;
            r_error <= 1'b0;
        end else begin
            if (w_accept) begin
                r_ready <= 1'b0;
            end else if (w_jtag_done) begin
                r_ready <= 1'b1;
            end
            if (w_overflow) begin
                r_error <= 1'b1;
            end else if (w_load_a) begin
                r_error <= 1'b0;
            end
        end
    end

    // Starvation counter: JTAG grants that leave a CPU request waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_cpu_grant) begin
            r_starve <= '0;
        end else if (w_jtag_grant) begin
            if (!w_cpu_req) begin
                r_starve <= '0;
            end else if (!w_starved) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

    // Hold the last CPU read data once the C_RD cycle has passed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rdata <= '0;
        end else if (w_in_crd) begin
            r_cpu_rdata <= ram_rdata;
        end
    end

endmodule
`default_nettype wire
